// File: rtl/pool2_rd_pkg.sv
// Shared state type and default widths for the pool2 result-map read sequencer.
package pool2_rd_pkg;

    localparam int POOL2_ADDR_W   = 12;
    localparam int POOL2_DATA_W   = 128;
    localparam int POOL2_READ_LAT = 2;
    localparam int POOL2_CNT_W    = POOL2_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pool2_rd_fifo.sv
// First-word-fall-through FIFO buffering RAM read data ahead of the output stream.
module pool2_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/pool2_rm_rd_ctrl.sv
// Streams a wrapping address range out of the pool2 result-map RAM with credit-based issue.
// Optional POOL2_RD_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_cnt).
module pool2_rm_rd_ctrl
    import pool2_rd_pkg::*;
#(
    parameter int ADDR_W     = POOL2_ADDR_W,
    parameter int DATA_W     = POOL2_DATA_W,
    parameter int READ_LAT   = POOL2_READ_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
`ifdef POOL2_RD_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int FC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH + READ_LAT + 1);

    rd_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
    logic [CNT_W-1:0]      iss_rem_q, iss_rem_d;
    logic [CNT_W-1:0]      out_rem_q, out_rem_d;
    logic [READ_LAT-1:0]   rd_vld_q, rd_vld_d;
    logic                  done_q, done_d;

    logic [DATA_W-1:0]     fifo_dout;
    logic [FC_W-1:0]       fifo_count;
    logic                  fifo_empty;
    logic [CRED_W-1:0]     inflight;
    logic                  credit_ok;
    logic                  issue;
    logic                  hs;

    pool2_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_vld_q[READ_LAT-1]),
        .din   (ram_doutb),
        .pop   (hs),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_dout : '0;
    assign hs      = m_valid && m_ready;
    assign m_last  = m_valid && (out_rem_q == CNT_W'(1));
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    // Reads still in the RAM pipe count against FIFO space so a late capture always fits.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + CRED_W'(rd_vld_q[i]);
        end
        credit_ok = (inflight + CRED_W'(fifo_count)) < CRED_W'(FIFO_DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        iss_rem_d   = iss_rem_q;
        out_rem_d   = out_rem_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        if (hs) begin
            out_rem_d = out_rem_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_d   = RUN;
                        addr_d    = base_addr;
                        iss_rem_d = word_count;
                        out_rem_d = word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    last_addr_d = addr_q;
                    iss_rem_d   = iss_rem_q - 1'b1;
                    if (iss_rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_vld_d    = '0;
        rd_vld_d[0] = issue;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end
    end

    assign ram_addrb = issue ? addr_q : last_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            iss_rem_q   <= '0;
            out_rem_q   <= '0;
            rd_vld_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            iss_rem_q   <= iss_rem_d;
            out_rem_q   <= out_rem_d;
            rd_vld_q    <= rd_vld_d;
            done_q      <= done_d;
        end
    end

`ifdef POOL2_RD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (busy && m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pool2_rm_rd_ctrl.sv
// Scoreboard bench for pool2_rm_rd_ctrl with a 2-cycle-latency RAM model.
module tb_pool2_rm_rd_ctrl;
    import pool2_rd_pkg::*;

    typedef struct {
        logic [127:0] d;
        logic         l;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [11:0]            base_addr;
    logic [POOL2_CNT_W-1:0] word_count;
    logic [11:0]            ram_addrb;
    logic [127:0]           ram_doutb;
    logic [127:0]           m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;
    logic                   busy;
    logic                   done;
`ifdef POOL2_RD_STALL_CNT_EN
    logic [31:0]            stall_cnt;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   last_rel = -1;
    int   issue_cnt = 0;
    int   issue_snap = 0;
    logic [11:0] prev_addrb = 12'hFFF;
    logic [11:0] ram_a1;
    exp_t sb[$];

    pool2_rm_rd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ram_addrb  (ram_addrb),
        .ram_doutb  (ram_doutb),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
`ifdef POOL2_RD_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input logic [11:0] a);
        return {4{20'hABCDE, a}};
    endfunction

    function automatic int rel();
        return cyc - t0 + 1;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ram_a1 <= ram_addrb;
        ram_doutb <= mk(ram_a1);
    end

    always @(negedge clk) begin
        if (ram_addrb != prev_addrb) issue_cnt++;
        prev_addrb = ram_addrb;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m_valid && m_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra_word: got %0h, expected no word", m_data);
            end else begin
                total--;
                e = sb.pop_front();
                chk("word_data", m_data, e.d);
                chk("word_last", {127'd0, m_last}, {127'd0, e.l});
                if (m_last) last_rel = rel();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [POOL2_CNT_W-1:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back('{mk(b + 12'(i)), (i == int'(n) - 1)});
        end
        step();
        start      = 1'b0;
        t0         = cyc;
        issue_snap = issue_cnt;
    endtask

    task automatic wait_done(input string nm, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, {127'd0, ok}, 128'd1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_addrb"}, {116'd0, ram_addrb}, 128'd0);
        chk({p, "_valid"}, {127'd0, m_valid}, 128'd0);
        chk({p, "_last"},  {127'd0, m_last},  128'd0);
        chk({p, "_data"},  m_data,            128'd0);
        chk({p, "_busy"},  {127'd0, busy},    128'd0);
        chk({p, "_done"},  {127'd0, done},    128'd0);
    endtask

    task automatic no_extra(input string nm, input int ncyc);
        int stray = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (m_valid) stray++;
        end
        chk(nm, 128'(stray), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a2 [4];
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; m_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk_reset("rst");
        step();
        rst_n = 1'b1;
        step();

        // Basic 8-word stream with latency and completion timing
        m_ready = 1'b1;
        do_start(12'h010, 13'd8);
        @(negedge clk);
        chk("t1_busy_c1", {127'd0, busy}, 128'd1);
        chk("t1_addrb_c1", {116'd0, ram_addrb}, 128'h010);
        for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
        chk("t1_first_valid_cyc", 128'(rel()), 128'd4);
        wait_done("t1_done_seen", 30);
        chk("t1_done_cyc", 128'(rel()), 128'd12);
        chk("t1_busy_at_done", {127'd0, busy}, 128'd0);
        chk("t1_last_cyc", 128'(last_rel), 128'd11);
        chk("t1_sb_empty", 128'(sb.size()), 128'd0);

        // Address wrap at the top of the RAM
        step();
        a2 = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        do_start(12'hFFE, 13'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_wrap_addr", {116'd0, ram_addrb}, {116'd0, a2[i]});
        end
        wait_done("t2_done_seen", 30);
        chk("t2_sb_empty", 128'(sb.size()), 128'd0);

        // Back-pressure: m_ready low for cycles 5..20
        step();
        do_start(12'h100, 13'd16);
        for (int i = 0; i < 80; i++) begin
            m_ready = !(rel() >= 5 && rel() <= 20);
            @(negedge clk);
            if (rel() == 20) chk("t3_issues_in_stall", 128'(issue_cnt - issue_snap), 128'd5);
            if (done) break;
            step();
        end
        m_ready = 1'b1;
        chk("t3_done_seen", {127'd0, done}, 128'd1);
        chk("t3_total_issues", 128'(issue_cnt - issue_snap), 128'd16);
        chk("t3_sb_empty", 128'(sb.size()), 128'd0);
`ifdef POOL2_RD_STALL_CNT_EN
        chk("t3_stall_cnt", {96'd0, stall_cnt}, 128'd16);
`endif

        // Zero-length command, then a start ignored while busy
        step();
        do_start(12'h050, 13'd0);
        @(negedge clk);
        chk("t4_done_c1", {127'd0, done}, 128'd1);
        chk("t4_busy_c1", {127'd0, busy}, 128'd0);
        chk("t4_valid_c1", {127'd0, m_valid}, 128'd0);
        step();
        @(negedge clk);
        chk("t4_done_c2", {127'd0, done}, 128'd0);
        step();
        do_start(12'h200, 13'd4);
        start = 1'b1; base_addr = 12'h300; word_count = 13'd9;
        step();
        start = 1'b0;
        @(negedge clk);
        wait_done("t4_done_seen", 30);
        no_extra("t4_no_extra_words", 12);
        chk("t4_sb_empty", 128'(sb.size()), 128'd0);

        // Reset in the middle of a run with two reads in flight
        step();
        do_start(12'h400, 13'd16);
        step();
        step();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_reset("midrst");
        step();
        step();
        rst_n = 1'b1;
        step();
        do_start(12'h500, 13'd2);
        @(negedge clk);
        wait_done("t5_done_seen", 30);
        no_extra("t5_no_stale_words", 12);
        chk("t5_sb_empty", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
